// File: rtl/seq1010_tx.sv
// seq1010_tx: serial frame transmitter. Each accepted word goes out as a 1010 preamble,
// the payload MSB first, an optional even-parity bit and a run of forced-zero gap bits.
`timescale 1ns/1ps
module seq1010_tx #(
  parameter int DATA_W    = 8,
  parameter int PARITY_EN = 1,
  parameter int GAP_BITS  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              dout,
  output logic              frame_active,
  output logic              sync_pulse
);

  localparam int MAX_A   = (DATA_W > 4) ? DATA_W : 4;
  localparam int MAX_LEN = (GAP_BITS > MAX_A) ? GAP_BITS : MAX_A;
  localparam int CNT_W   = $clog2(MAX_LEN) + 1;

  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] PRE_LOAD  = CNT_W'(32'd3);
  localparam logic [CNT_W-1:0] DATA_LOAD = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'((GAP_BITS > 0) ? (GAP_BITS - 1) : 0);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PRE  = 3'd1,
    ST_DATA = 3'd2,
    ST_PAR  = 3'd3,
    ST_GAP  = 3'd4
  } state_t;

  function automatic logic even_parity(input logic [DATA_W-1:0] word);
    return ^word;
  endfunction

  state_t             state_r;
  state_t             state_nxt_s;
  logic [CNT_W-1:0]   cnt_r;
  logic [CNT_W-1:0]   cnt_nxt_s;
  logic [DATA_W-1:0]  shift_r;
  logic               par_r;
  logic               accept_s;
  logic               last_s;
  logic               dout_nxt_s;
  logic               active_nxt_s;
  logic               sync_nxt_s;
  logic               ready_nxt_s;

  assign accept_s = tx_valid & tx_ready & (state_r == ST_IDLE);
  assign last_s   = (cnt_r == CNT_ZERO);

  // Next state and shared down-counter; the counter is reloaded on every state entry
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_nxt_s = ST_PRE;
          cnt_nxt_s   = PRE_LOAD;
        end else begin
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = CNT_ZERO;
        end
      end
      ST_PRE: begin
        if (last_s) begin
          state_nxt_s = ST_DATA;
          cnt_nxt_s   = DATA_LOAD;
        end else begin
          cnt_nxt_s   = cnt_r - CNT_ONE;
        end
      end
      ST_DATA: begin
        if (!last_s) begin
          cnt_nxt_s   = cnt_r - CNT_ONE;
        end else if (PARITY_EN != 0) begin
          state_nxt_s = ST_PAR;
          cnt_nxt_s   = CNT_ZERO;
        end else if (GAP_BITS > 0) begin
          state_nxt_s = ST_GAP;
          cnt_nxt_s   = GAP_LOAD;
        end else begin
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = CNT_ZERO;
        end
      end
      ST_PAR: begin
        if (GAP_BITS > 0) begin
          state_nxt_s = ST_GAP;
          cnt_nxt_s   = GAP_LOAD;
        end else begin
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = CNT_ZERO;
        end
      end
      ST_GAP: begin
        if (last_s) begin
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = CNT_ZERO;
        end else begin
          cnt_nxt_s   = cnt_r - CNT_ONE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = CNT_ZERO;
      end
    endcase
  end

  // Line values for the coming cycle, decoded from the state being entered
  always_comb begin
    dout_nxt_s   = 1'b0;
    active_nxt_s = 1'b0;
    sync_nxt_s   = 1'b0;
    ready_nxt_s  = 1'b0;
    case (state_nxt_s)
      ST_IDLE: begin
        ready_nxt_s = 1'b1;
      end
      ST_PRE: begin
        // counter 3,2,1,0 maps onto line bits 1,0,1,0
        dout_nxt_s   = cnt_nxt_s[0];
        active_nxt_s = 1'b1;
        sync_nxt_s   = (cnt_nxt_s == CNT_ZERO);
      end
      ST_DATA: begin
        dout_nxt_s   = shift_r[DATA_W-1];
        active_nxt_s = 1'b1;
      end
      ST_PAR: begin
        dout_nxt_s   = par_r;
        active_nxt_s = 1'b1;
      end
      ST_GAP: begin
        dout_nxt_s   = 1'b0;
      end
      default: begin
        ready_nxt_s  = 1'b0;
      end
    endcase
  end

  // State, counter and registered line outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      cnt_r        <= CNT_ZERO;
      dout         <= 1'b0;
      frame_active <= 1'b0;
      sync_pulse   <= 1'b0;
      tx_ready     <= 1'b1;
    end else begin
      state_r      <= state_nxt_s;
      cnt_r        <= cnt_nxt_s;
      dout         <= dout_nxt_s;
      frame_active <= active_nxt_s;
      sync_pulse   <= sync_nxt_s;
      tx_ready     <= ready_nxt_s;
    end
  end

  // Payload shift register and parity latch, loaded only on the handshake
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_r <= {DATA_W{1'b0}};
      par_r   <= 1'b0;
    end else if (accept_s) begin
      shift_r <= tx_data;
      par_r   <= even_parity(tx_data);
    end else if (state_nxt_s == ST_DATA) begin
      shift_r <= shift_r << 1'b1;
      par_r   <= par_r;
    end else begin
      shift_r <= shift_r;
      par_r   <= par_r;
    end
  end

endmodule

// File: tb/tb_seq1010_tx.sv
// Bench for seq1010_tx: per-cycle expected line values queued on each handshake, plus a
// DATA_W=4 / no-parity / no-gap instance looped into a Mealy 1010 detector model.
`timescale 1ns/1ps
module tb_seq1010_tx;

  typedef struct packed {
    logic dout;
    logic act;
    logic sync;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       dout;
  logic       frame_active;
  logic       sync_pulse;

  logic [3:0] tx_data4 = 4'h0;
  logic       tx_valid4 = 1'b0;
  logic       tx_ready4;
  logic       dout4;
  logic       frame_active4;
  logic       sync4;

  logic [2:0] hist4;
  logic       y4;
  logic       det_on = 1'b0;
  int         y_cnt = 0;
  int         cyc = 0;
  int         checks = 0;
  int         failures = 0;
  exp_t       sb1[$];
  exp_t       sb4[$];

  seq1010_tx #(.DATA_W(8), .PARITY_EN(1), .GAP_BITS(2)) u_dut (
    .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .dout(dout), .frame_active(frame_active), .sync_pulse(sync_pulse)
  );

  seq1010_tx #(.DATA_W(4), .PARITY_EN(0), .GAP_BITS(0)) u_dut4 (
    .clk(clk), .reset(reset), .tx_data(tx_data4), .tx_valid(tx_valid4),
    .tx_ready(tx_ready4), .dout(dout4), .frame_active(frame_active4), .sync_pulse(sync4)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Mealy 1010 detector: fires while the final 0 is on the line
  assign y4 = (hist4 == 3'b101) && (dout4 == 1'b0);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
    end
  endtask

  function automatic exp_t mk(input logic d, input logic a, input logic s);
    exp_t e;
    e.dout = d;
    e.act  = a;
    e.sync = s;
    return e;
  endfunction

  task automatic push_frame1(input logic [7:0] w);
    logic [3:0] pre;
    pre = 4'b1010;
    for (int i = 3; i >= 0; i--) sb1.push_back(mk(pre[i], 1'b1, (i == 0)));
    for (int i = 7; i >= 0; i--) sb1.push_back(mk(w[i], 1'b1, 1'b0));
    sb1.push_back(mk((($countones(w) % 2) == 1), 1'b1, 1'b0));
    repeat (2) sb1.push_back(mk(1'b0, 1'b0, 1'b0));
  endtask

  task automatic push_frame4(input logic [3:0] w);
    logic [3:0] pre;
    pre = 4'b1010;
    for (int i = 3; i >= 0; i--) sb4.push_back(mk(pre[i], 1'b1, (i == 0)));
    for (int i = 3; i >= 0; i--) sb4.push_back(mk(w[i], 1'b1, 1'b0));
  endtask

  always @(negedge clk) begin
    if (reset) begin
      sb1.delete();
    end else if (sb1.size() != 0) begin
      check("dout", dout, sb1[0].dout);
      check("frame_active", frame_active, sb1[0].act);
      check("sync_pulse", sync_pulse, sb1[0].sync);
      check("tx_ready_busy", tx_ready, 1'b0);
      sb1.delete(0);
    end else begin
      check("idle_dout", dout, 1'b0);
      check("idle_frame_active", frame_active, 1'b0);
      check("idle_sync_pulse", sync_pulse, 1'b0);
      check("idle_tx_ready", tx_ready, 1'b1);
      if (tx_valid) push_frame1(tx_data);
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      sb4.delete();
      hist4 <= 3'b000;
      y_cnt <= 0;
    end else begin
      if (det_on) begin
        check("melfsm_y_vs_sync", y4, sync4);
        if (y4) y_cnt <= y_cnt + 1;
      end
      hist4 <= {hist4[1:0], dout4};
      if (sb4.size() != 0) begin
        check("dout4", dout4, sb4[0].dout);
        check("frame_active4", frame_active4, sb4[0].act);
        check("sync4", sync4, sb4[0].sync);
        check("tx_ready4_busy", tx_ready4, 1'b0);
        sb4.delete(0);
      end else begin
        check("idle_dout4", dout4, 1'b0);
        check("idle_frame_active4", frame_active4, 1'b0);
        check("idle_tx_ready4", tx_ready4, 1'b1);
        if (tx_valid4) push_frame4(tx_data4);
      end
    end
  end

  task automatic send(input bit to4, input logic [7:0] w, input bit hold);
    logic acc;
    int   n;
    acc = 1'b0;
    n   = 0;
    if (to4) begin
      tx_data4  = w[3:0];
      tx_valid4 = 1'b1;
    end else begin
      tx_data  = w;
      tx_valid = 1'b1;
    end
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = to4 ? tx_ready4 : tx_ready;
      @(posedge clk);
      #1;
      n++;
    end
    check("accept_within_bound", acc, 1'b1);
    if (!hold) begin
      if (to4) tx_valid4 = 1'b0;
      else     tx_valid  = 1'b0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int k1;
    int k2;

    // reset asserted mid-cycle, outputs must settle before any clock edge
    #2 reset = 1'b1;
    #1;
    check("rst_dout", dout, 1'b0);
    check("rst_frame_active", frame_active, 1'b0);
    check("rst_sync_pulse", sync_pulse, 1'b0);
    check("rst_tx_ready", tx_ready, 1'b1);
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // single frame with defaults
    send(1'b0, 8'hA5, 1'b0);
    repeat (20) @(posedge clk);
    #1;

    // tx_valid held across two words: accepts 16 cycles apart
    send(1'b0, 8'h3C, 1'b1);
    k1 = cyc;
    send(1'b0, 8'hFF, 1'b0);
    k2 = cyc;
    check("accept_spacing", k2 - k1, 16);
    repeat (20) @(posedge clk);
    #1;

    // data changes while busy must not disturb the frame in flight; then all-zero payload
    send(1'b0, 8'h81, 1'b0);
    send(1'b0, 8'h00, 1'b0);
    repeat (20) @(posedge clk);
    #1;

    // abort in the middle of the payload, then a clean frame
    send(1'b0, 8'hF0, 1'b0);
    repeat (7) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("abort_dout", dout, 1'b0);
    check("abort_frame_active", frame_active, 1'b0);
    check("abort_sync_pulse", sync_pulse, 1'b0);
    check("abort_tx_ready", tx_ready, 1'b1);
    @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    send(1'b0, 8'h01, 1'b0);
    repeat (20) @(posedge clk);
    #1;

    // narrow instance into the detector: one pulse per frame, on the sync cycle
    det_on = 1'b1;
    send(1'b1, 8'h0F, 1'b0);
    repeat (12) @(posedge clk);
    #1;
    det_on = 1'b0;
    check("melfsm_pulses", y_cnt, 1);

    send(1'b1, 8'h0F, 1'b1);
    k1 = cyc;
    send(1'b1, 8'h0A, 1'b0);
    k2 = cyc;
    check("period4", k2 - k1, 9);
    repeat (12) @(posedge clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq1010_tx.md
Name: seq1010_tx

Overview:
Serial frame transmitter that drives the 1010 sync-pattern protocol consumed by the team's Mealy 1010 detector (melfsm).
- Accepts a parallel word over a valid/ready handshake.
- Emits a fixed 1010 preamble, the payload MSB-first, an optional even-parity bit, then a run of idle zeros.
- Sits upstream of the detector on the single-bit serial line.
- Used as the stimulus source for the detector and as a standalone serial link head.

Parameters:
DATA_W, 8, payload width in bits; must be >= 1.
PARITY_EN, 1, 1 = append one even-parity bit after the payload; 0 = no parity bit.
GAP_BITS, 2, number of forced-zero bits after each frame; must be >= 0; 0 = no gap state.

Ports:
clk  input  1  rising-edge clock.
reset  input  1  asynchronous, active-high reset.
tx_data  input  DATA_W  payload word; sampled only on handshake.
tx_valid  input  1  payload available.
tx_ready  output  1  transmitter can accept a word; high only in IDLE.
dout  output  1  serial line; registered.
frame_active  output  1  high while dout carries preamble, payload or parity bits; registered.
sync_pulse  output  1  high for exactly the cycle in which the last preamble bit (0) is on dout; registered.

Behaviour:
- Reset (async assert, sync release on clk):
  - state = IDLE, bit counter = 0, dout = 0, frame_active = 0, sync_pulse = 0, tx_ready = 1.
  - The data and parity registers hold no defined value until the first handshake.
- FSM states and transitions:
  - IDLE: dout = 0.
    - On tx_valid && tx_ready at an edge: latch tx_data into a shift register; latch parity = XOR of all tx_data bits.
    - Next state is PRE.
  - PRE: 4 cycles; dout = 1, 0, 1, 0 in order; frame_active = 1.
    - sync_pulse = 1 on the 4th cycle only.
    - Exit to DATA.
  - DATA: DATA_W cycles; dout = latched data MSB first (bit DATA_W-1 down to bit 0).
    - Exit to PAR if PARITY_EN = 1.
    - Otherwise exit to GAP if GAP_BITS > 0, else to IDLE.
  - PAR: 1 cycle; dout = latched parity bit. The total count of 1s in payload plus parity is even.
    - Exit to GAP if GAP_BITS > 0, else to IDLE.
  - GAP: GAP_BITS cycles; dout = 0, frame_active = 0.
    - Exit to IDLE.
- Latency: handshake at edge k → first preamble bit (1) on dout in the cycle after edge k.
- Frame period: 1 (IDLE) + 4 + DATA_W + PARITY_EN + GAP_BITS cycles. With defaults, back-to-back frames occur every 16 cycles.
- tx_ready is registered. It deasserts in the cycle after acceptance and reasserts on entry to IDLE.
- While tx_ready = 0, tx_valid and tx_data are ignored. The producer holds tx_valid until the handshake; the block never drops a held word.
- The bit counter is a single shared down-counter of width clog2(max(4, DATA_W, GAP_BITS)) + 1. It is reloaded on every state entry; there is no wrap-around.
- Reset asserted mid-frame: the frame is aborted immediately. All outputs take their reset values asynchronously. No partial-frame resumption.
- DATA_W = 1: DATA lasts exactly one cycle.
- All-zero payload: preamble and parity still emitted; parity = 0.
- No bit stuffing. Payload bits can form 1010 on the line; the receiver is responsible for disambiguation using frame length.

Test Plan:
1. Assert reset mid-cycle, then release → dout = 0, frame_active = 0, sync_pulse = 0, tx_ready = 1 before the first clock edge.
2. Defaults, send tx_data = 0xA5 once → dout from cycle k+1 = 1010 1010 0101 0 00. sync_pulse on the 4th bit; frame_active high for 13 cycles; tx_ready back high at cycle k+16.
3. tx_valid held high with 0x3C then 0xFF → second preamble starts exactly 16 cycles after the first. Parity bits are 0 and 0. tx_ready is low for 15 cycles between accepts.
4. Change tx_data to 0x00 while busy during the 0x81 frame → transmitted payload remains 10000001 and parity = 0.
5. Assert reset during DATA bit 3 → dout = 0 immediately. After release, a new 0x01 frame transmits a clean 1010 00000001 1 00.
6. PARITY_EN = 0, GAP_BITS = 0, DATA_W = 4, send 0xF, loopback into melfsm → line = 1010 1111 with a 9-cycle period. melfsm y pulses once per frame, coincident with sync_pulse.
